if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register.
- Sits directly upstream of the instruction decoder. It holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 for the ID stage.
- Selects the next PC from four sources: sequential, J target, JR target or EX-resolved branch target.
- Handles stall, flush and bubble insertion for the pipeline.

---
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Chooses the next PC (sequential, J, JR, EX branch) and handles stall, flush and bubbles.
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        J_id,
  input  logic        JR_id,
  input  logic [31:0] RsData_id,
  input  logic        Branch_ex,
  input  logic [31:0] BranchAddr_ex,
  input  logic [31:0] Instruction_if,
  output logic [31:0] PC,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_plus4_id,
  output logic        Valid_id,
  output logic        Redirect
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] branch_target;
  logic        jump_take;
  logic        flush;
  logic        hold;

  assign pc_plus4      = PC + 32'd4;
  assign jump_take     = Valid_id & (J_id | JR_id);
  assign jump_target   = {PC_plus4_id[31:28], Instruction_id[25:0], 2'b00};
  assign jr_target     = {RsData_id[31:2], 2'b00};
  assign branch_target = {BranchAddr_ex[31:2], 2'b00};

  // Next-PC selection; depends only on registered state and control inputs,
  // never on Instruction_if.
  always_comb begin
    pc_next = pc_plus4;
    flush   = 1'b0;
    hold    = 1'b0;
    if (Branch_ex) begin
      pc_next = branch_target;
      flush   = 1'b1;
    end else if (Stall) begin
      pc_next = PC;
      hold    = 1'b1;
    end else if (Valid_id & JR_id) begin
      pc_next = jr_target;
      flush   = 1'b1;
    end else if (Valid_id & J_id) begin
      pc_next = jump_target;
      flush   = 1'b1;
    end
  end

  assign Redirect = ~reset & (Branch_ex | (~Stall & jump_take));

  always_ff @(posedge clk) begin
    if (reset) begin
      PC             <= PC_RESET;
      Instruction_id <= NOP_INSTR;
      PC_plus4_id    <= 32'h0;
      Valid_id       <= 1'b0;
    end else begin
      PC <= pc_next;
      // A flushed slot still records PC+4 so its contents stay deterministic.
      if (flush) begin
        Instruction_id <= NOP_INSTR;
        PC_plus4_id    <= pc_plus4;
        Valid_id       <= 1'b0;
      end else if (!hold) begin
        Instruction_id <= Instruction_if;
        PC_plus4_id    <= pc_plus4;
        Valid_id       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the driver pushes hand-computed expectations,
// a monitor pops and compares them against the DUT each cycle.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        J_id;
  logic        JR_id;
  logic [31:0] RsData_id;
  logic        Branch_ex;
  logic [31:0] BranchAddr_ex;
  logic [31:0] Instruction_if;
  logic [31:0] PC;
  logic [31:0] Instruction_id;
  logic [31:0] PC_plus4_id;
  logic        Valid_id;
  logic        Redirect;

  int tests_run = 0;
  int tests_failed = 0;

  // {redirect, pc, instruction_id, pc_plus4_id, valid_id}
  logic [97:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .Stall         (Stall),
    .J_id          (J_id),
    .JR_id         (JR_id),
    .RsData_id     (RsData_id),
    .Branch_ex     (Branch_ex),
    .BranchAddr_ex (BranchAddr_ex),
    .Instruction_if(Instruction_if),
    .PC            (PC),
    .Instruction_id(Instruction_id),
    .PC_plus4_id   (PC_plus4_id),
    .Valid_id      (Valid_id),
    .Redirect      (Redirect)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: mem_word = 32'h2008_0005;
      32'h0000_0004: mem_word = 32'h2009_0003;
      32'h0000_0008: mem_word = 32'h200A_0001;
      32'h0000_000C: mem_word = 32'h200B_0002;
      32'h0000_0010: mem_word = 32'h0800_0040;
      32'h0000_0100: mem_word = 32'h03E0_0008;
      default:       mem_word = 32'hC000_0000 ^ addr;
    endcase
  endfunction

  always_comb Instruction_if = mem_word(PC);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Redirect is sampled before the edge, registers after it.
  initial begin
    logic [97:0] e;
    string       n;
    logic        red;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        red = Redirect;
        @(posedge clk);
        #2;
        check({n, ".redirect"}, {31'h0, red}, {31'h0, e[97]});
        check({n, ".pc"}, PC, e[96:65]);
        check({n, ".instr_id"}, Instruction_id, e[64:33]);
        check({n, ".pc4_id"}, PC_plus4_id, e[32:1]);
        check({n, ".valid_id"}, {31'h0, Valid_id}, {31'h0, e[0]});
      end
    end
  end

  task automatic step(input string name,
                      input logic rst, input logic stl, input logic j, input logic jr,
                      input logic [31:0] rs, input logic br, input logic [31:0] ba,
                      input logic e_red, input logic [31:0] e_pc, input logic [31:0] e_ins,
                      input logic [31:0] e_p4, input logic e_v);
    reset         = rst;
    Stall         = stl;
    J_id          = j;
    JR_id         = jr;
    RsData_id     = rs;
    Branch_ex     = br;
    BranchAddr_ex = ba;
    exp_q.push_back({e_red, e_pc, e_ins, e_p4, e_v});
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Stall = 1'b0; J_id = 1'b0; JR_id = 1'b0;
    RsData_id = 32'h0; Branch_ex = 1'b0; BranchAddr_ex = 32'h0;
    @(posedge clk);
    #1;
    //    name      rst stl j  jr  rs            br  ba            red pc            ins           p4            v
    step("rst0",     1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0);
    step("rst1",     1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0);
    step("fetch1",   0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         32'h2008_0005, 32'h4,       1);
    step("fetch2",   0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         32'h2009_0003, 32'h8,       1);
    step("fetch3",   0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hC,         32'h200A_0001, 32'hC,       1);
    step("fetch4",   0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h10,        32'h200B_0002, 32'h10,      1);
    step("fetch_j",  0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h14,        32'h0800_0040, 32'h14,      1);
    step("j_take",   0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h100,       32'h0,        32'h18,       0);
    step("j_bubble", 0, 0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h104,       32'h03E0_0008, 32'h104,     1);
    step("jr_stl1",  0, 1, 0, 1, 32'h0000_2003, 0, 32'h0,         0, 32'h104,       32'h03E0_0008, 32'h104,     1);
    step("jr_stl2",  0, 1, 0, 1, 32'h0000_2003, 0, 32'h0,         0, 32'h104,       32'h03E0_0008, 32'h104,     1);
    step("jr_take",  0, 0, 0, 1, 32'h0000_2003, 0, 32'h0,         1, 32'h2000,      32'h0,        32'h108,      0);
    step("jr_fet1",  0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h2004,      32'hC000_2000, 32'h2004,    1);
    step("jr_fet2",  0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h2008,      32'hC000_2004, 32'h2008,    1);
    step("br_stall", 0, 1, 1, 0, 32'h0,         1, 32'h0000_0043, 1, 32'h40,        32'h0,        32'h200C,     0);
    step("br_fet",   0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h44,        32'hC000_0040, 32'h44,      1);
    step("j_and_jr", 0, 0, 1, 1, 32'h0000_3001, 0, 32'h0,         1, 32'h3000,      32'h0,        32'h48,       0);
    step("br_top",   0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0,        32'h3004,     0);
    step("wrap",     0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h3FFF_FFFC, 32'h0,       1);
    step("wrap_nxt", 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         32'h2008_0005, 32'h4,       1);
    step("rst_mid",  1, 1, 0, 0, 32'h0,         1, 32'h0000_0040, 0, 32'h0,         32'h0,        32'h0,        0);
    step("rst_rel1", 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         32'h2008_0005, 32'h4,       1);
    step("rst_rel2", 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         32'h2009_0003, 32'h8,       1);
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
